// File: rtl/paralelo_serial_tx_if.sv
// -----------------------------------------------------------------------------
// paralelo_serial_tx_if
//   Byte handshake between the upper layer and the serial transmitter.
//
//   Signals
//     data_in    8  byte offered by the upper layer
//     valid_in   1  data_in is valid this cycle
//     ready_out  1  transmitter holding register can accept a byte this cycle
//
//   Modports
//     master  upper layer: drives data_in/valid_in, observes ready_out
//     slave   transmitter: observes data_in/valid_in, drives ready_out
// -----------------------------------------------------------------------------
interface paralelo_serial_tx_if;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;

  modport master (
    output data_in,
    output valid_in,
    input  ready_out
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output ready_out
  );
endinterface : paralelo_serial_tx_if

// File: rtl/paralelo_serial_tx.sv
// -----------------------------------------------------------------------------
// paralelo_serial_tx
//   Transmit end of the PHY serial link. Bytes arrive over a valid/ready
//   handshake into a one-byte holding register and are serialised MSB-first,
//   one bit per clk_32f, eight cycles per word. Every word slot with no byte
//   available carries COMMA. After reset, SYNC_WORDS comma words are sent
//   before any data so the far-end receiver can align.
//
//   Parameters
//     SYNC_WORDS  comma words sent after reset before data (1..15)
//     COMMA       sync / idle word
//
//   Ports
//     clk_32f    in   bit clock, the only clock
//     rst_L      in   asynchronous active-low reset
//     byte_if    slave modport of paralelo_serial_tx_if (data_in, valid_in,
//                ready_out)
//     data_out   out  serial bit, registered
//     active     out  sync preamble done, data words may now be sent
//     err_comma  out  one-cycle pulse when a COMMA byte is refused
//                     (only with PS_TX_COMMA_BLOCK_EN)
//
//   Build option
//     PS_TX_COMMA_BLOCK_EN  when defined, bytes equal to COMMA are refused at
//                           the handshake and flagged on err_comma; when
//                           undefined they are sent like any other byte and
//                           the err_comma port does not exist.
// -----------------------------------------------------------------------------
module paralelo_serial_tx #(
  parameter int unsigned SYNC_WORDS = 4,
  parameter logic [7:0]  COMMA      = 8'hBC
) (
  input  logic                 clk_32f,
  input  logic                 rst_L,
  paralelo_serial_tx_if.slave  byte_if,
  output logic                 data_out,
  output logic                 active
`ifdef PS_TX_COMMA_BLOCK_EN
  ,
  output logic                 err_comma
`endif
);

  // Sync counter value on the load edge of the last preamble word.
  localparam logic [3:0] SYNC_LAST = 4'(SYNC_WORDS - 1);

  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_DATA = 1'b1
  } state_t;

  state_t      state_reg;
  logic [2:0]  bit_cnt_reg;
  logic [7:0]  shift_reg;
  logic [7:0]  hold_reg;
  logic        hold_full_reg;
  logic [3:0]  sync_cnt_reg;

  logic        load_edge;
  logic [7:0]  word_next;
  logic        accept;
  logic        comma_refused;

  // A new word enters the shifter whenever the bit counter wraps to zero.
  assign load_edge = (bit_cnt_reg == 3'd0);

  // Handshake: a byte can be taken whenever the holding register is empty.
  // Nothing bypasses hold into the shifter, so ready depends only on hold.
  assign byte_if.ready_out = ~hold_full_reg;

`ifdef PS_TX_COMMA_BLOCK_EN
  // A COMMA byte would be indistinguishable from idle fill at the receiver,
  // so it is refused at the handshake instead of being silently lost.
  assign comma_refused = byte_if.valid_in && ~hold_full_reg &&
                         (byte_if.data_in == COMMA);
`else
  assign comma_refused = 1'b0;
`endif

  assign accept = byte_if.valid_in && ~hold_full_reg && ~comma_refused;

  // Word chosen for the next load: preamble and idle slots carry COMMA,
  // a held byte is used only once the preamble is finished.
  always_comb begin
    word_next = COMMA;
    if ((state_reg == ST_DATA) && hold_full_reg) begin
      word_next = hold_reg;
    end
  end

  always_ff @(posedge clk_32f or negedge rst_L) begin
    if (!rst_L) begin
      state_reg     <= ST_SYNC;
      bit_cnt_reg   <= 3'd0;
      shift_reg     <= 8'd0;
      hold_reg      <= 8'd0;
      hold_full_reg <= 1'b0;
      sync_cnt_reg  <= 4'd0;
      data_out      <= 1'b0;
      active        <= 1'b0;
`ifdef PS_TX_COMMA_BLOCK_EN
      err_comma     <= 1'b0;
`endif
    end else begin
      bit_cnt_reg <= bit_cnt_reg + 3'd1;

      if (load_edge) begin
        // The MSB goes straight to the wire on the load edge; the shifter
        // copy supplies the remaining seven bits.
        shift_reg <= word_next;
        data_out  <= word_next[7];

        case (state_reg)
          ST_SYNC: begin
            sync_cnt_reg <= sync_cnt_reg + 4'd1;
            // active rises together with the load of the final sync word,
            // so the first data slot is the word after it.
            if (sync_cnt_reg == SYNC_LAST) begin
              state_reg <= ST_DATA;
              active    <= 1'b1;
            end
          end
          ST_DATA: begin
            if (hold_full_reg) begin
              hold_full_reg <= 1'b0;
            end
          end
          default: begin
            state_reg <= ST_SYNC;
          end
        endcase
      end else begin
        data_out <= shift_reg[3'd7 - bit_cnt_reg];
      end

      // Capture only ever happens with hold empty, while draining needs hold
      // full, so the two never collide on the same edge.
      if (accept) begin
        hold_reg      <= byte_if.data_in;
        hold_full_reg <= 1'b1;
      end

`ifdef PS_TX_COMMA_BLOCK_EN
      err_comma <= comma_refused;
`endif
    end
  end

endmodule : paralelo_serial_tx

// File: tb/tb_paralelo_serial_tx.sv
// -----------------------------------------------------------------------------
// tb_paralelo_serial_tx
//   Randomised bench for paralelo_serial_tx. A stream-level reference model
//   numbers the clock edges since reset release, splits them into 8-edge word
//   slots, fills the first SYNC_WORDS slots with COMMA and every later slot
//   with the oldest accepted byte (or COMMA when none is waiting). Every cycle
//   the serial bit, active, ready_out (and err_comma when built in) are
//   compared against that model.
// -----------------------------------------------------------------------------
module tb_paralelo_serial_tx;

  localparam int         SW    = 4;
  localparam logic [7:0] COMMA = 8'hBC;

  logic clk_32f = 1'b0;
  logic rst_L   = 1'b0;
  logic data_out;
  logic active;
`ifdef PS_TX_COMMA_BLOCK_EN
  logic err_comma;
`endif

  paralelo_serial_tx_if byte_if ();

  paralelo_serial_tx #(
    .SYNC_WORDS (SW),
    .COMMA      (COMMA)
  ) dut (
    .clk_32f   (clk_32f),
    .rst_L     (rst_L),
    .byte_if   (byte_if),
    .data_out  (data_out),
`ifdef PS_TX_COMMA_BLOCK_EN
    .err_comma (err_comma),
`endif
    .active    (active)
  );

  always #5 clk_32f = ~clk_32f;

  // Reference model state
  int         n_edge;        // edges since reset release
  logic [7:0] cur_word;      // word occupying the current slot
  logic [7:0] hold_q[$];     // bytes accepted but not yet sent (depth <= 1)
  logic       exp_bit;
  logic       exp_err;

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %02h expected %02h at edge %0d time %0t", tag, obs, exp, n_edge, $time);
    end
  endtask

  // Advance the model by one clock edge, given the inputs seen at that edge.
  task automatic model_edge(input logic v, input logic [7:0] d);
    logic       was_empty;
    logic       blocked;
    logic [2:0] pos;
    int         slot;
    was_empty = (hold_q.size() == 0);
    n_edge++;
    pos  = 3'((n_edge - 1) % 8);
    slot = (n_edge - 1) / 8;
    if (pos == 3'd0) begin
      if (slot < SW || hold_q.size() == 0) begin
        cur_word = COMMA;
      end else begin
        cur_word = hold_q.pop_front();
        $display("send   byte %02h in slot %0d (edge %0d)", cur_word, slot, n_edge);
      end
    end
    exp_bit = cur_word[3'd7 - pos];
    exp_err = 1'b0;
    if (v && was_empty) begin
      blocked = 1'b0;
`ifdef PS_TX_COMMA_BLOCK_EN
      blocked = (d == COMMA);
`endif
      if (blocked) begin
        exp_err = 1'b1;
        $display("refuse byte %02h at edge %0d", d, n_edge);
      end else begin
        hold_q.push_back(d);
        $display("accept byte %02h at edge %0d", d, n_edge);
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_data_out"}, 8'(data_out), 8'd0);
    check({tag, "_active"},   8'(active), 8'd0);
    check({tag, "_ready"},    8'(byte_if.ready_out), 8'd1);
`ifdef PS_TX_COMMA_BLOCK_EN
    check({tag, "_err"},      8'(err_comma), 8'd0);
`endif
  endtask

  // One clock: drive inputs (away from the edge), take the edge, sample #1 later.
  task automatic step(input logic v, input logic [7:0] d);
    byte_if.valid_in = v;
    byte_if.data_in  = d;
    @(posedge clk_32f);
    if (rst_L) model_edge(v, d);
    #1;
    if (rst_L) begin
      check("data_out", 8'(data_out), 8'(exp_bit));
      check("active",   8'(active), 8'(n_edge >= 8 * (SW - 1) + 1));
      check("ready",    8'(byte_if.ready_out), 8'(hold_q.size() == 0));
`ifdef PS_TX_COMMA_BLOCK_EN
      check("err_comma", 8'(err_comma), 8'(exp_err));
`endif
    end else begin
      check_reset_values("in_reset");
    end
  endtask

  // Asynchronous reset applied between edges, checked before the next edge.
  task automatic async_reset();
    #3;
    rst_L = 1'b0;
    #1;
    check_reset_values("async_reset");
    n_edge   = 0;
    cur_word = COMMA;
    hold_q.delete();
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00);
    rst_L = 1'b1;
  endtask

  task automatic random_run(input int cycles, input int valid_pct, input int comma_pct);
    logic       v;
    logic [7:0] d;
    for (int i = 0; i < cycles; i++) begin
      v = ($urandom_range(99, 0) < valid_pct);
      d = ($urandom_range(99, 0) < comma_pct) ? COMMA : 8'($urandom);
      step(v, d);
    end
  endtask

  initial begin
    bit found;
    n_edge   = 0;
    cur_word = COMMA;
    exp_bit  = 1'b0;
    exp_err  = 1'b0;
    byte_if.valid_in = 1'b0;
    byte_if.data_in  = 8'h00;

    // Reset held across several edges, then release.
    #1;
    check_reset_values("power_on");
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00);
    rst_L = 1'b1;

    // Preamble and idle fill with nothing offered.
    for (int i = 0; i < 48; i++) step(1'b0, 8'h00);

    // Single byte after active, then idle.
    step(1'b1, 8'hA5);
    for (int i = 0; i < 24; i++) step(1'b0, 8'h00);

    // Back-to-back bytes with valid held high.
    step(1'b1, 8'h12);
    while (!byte_if.ready_out) step(1'b1, 8'h12);
    step(1'b1, 8'h34);
    while (!byte_if.ready_out) step(1'b1, 8'h34);
    step(1'b1, 8'h56);
    for (int i = 0; i < 30; i++) step(1'b0, 8'h00);

    // COMMA offered as data.
    step(1'b1, COMMA);
    for (int i = 0; i < 20; i++) step(1'b0, 8'h00);

    // Random traffic: sparse, then saturated.
    random_run(400, 30, 10);
    random_run(200, 100, 5);

    // Byte offered during the preamble is held and sent in the first data slot.
    async_reset();
    step(1'b1, 8'h77);
    for (int i = 0; i < 50; i++) step(1'b1, 8'($urandom));
    random_run(100, 50, 10);

    // Mid-word reset with hold full: held byte must never appear.
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(1'b1, 8'($urandom));
      if (n_edge > 8 * SW + 8 && (n_edge % 8) == 3 && hold_q.size() == 1) found = 1'b1;
    end
    check("find_midword_full", 8'(found), 8'd1);
    async_reset();
    for (int i = 0; i < 60; i++) step(1'b0, 8'h00);
    random_run(150, 60, 10);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  // Hard time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete in time");
    $fatal(1, "timeout");
  end

endmodule : tb_paralelo_serial_tx
